// File: rtl/axis_vfifo_tester.sv
// -----------------------------------------------------------------------------
// axis_vfifo_tester
//
// Traffic generator and checker for an AXI-stream virtual FIFO. Each run writes
// DEPTH beats of per-channel counting data in bursts of BURST_LEN. It then
// drains DEPTH beats back from the FIFO. A read phase gives up after TIMEOUT
// consecutive cycles with no beat. After RUNS runs the block parks in DONE.
// When RUNS is 0 it loops forever.
//
// Optional feature: define AXIS_TESTER_CHECK_EN to compare every accepted read
// beat against the expected per-channel counter and count mismatches in
// ERR_CNT. Without the macro ERR_CNT is tied to 0 and read beats are only
// counted.
//
// Ports
//   BUS_CLK       sole clock, rising edge
//   BUS_RST       synchronous, active-high reset
//   START         pulse; starts a test from IDLE or DONE, ignored while busy
//   tx_*          AXI-stream master toward the FIFO (tvalid/tready/tlast/
//                 tdata/tdest)
//   rx_*          AXI-stream slave from the FIFO (tvalid/tready/tlast/
//                 tdata/tdest); rx_tlast never ends a phase
//   BUSY          high in WR, WR_WAIT and RD
//   DONE          high once the requested number of runs has finished
//   TIMEOUT_FLAG  sticky: a read phase ended on the idle timeout
//   RUN_CNT       completed runs, wraps at 8 bits
//   ERR_CNT       read data mismatches, saturating (check build only)
// -----------------------------------------------------------------------------
module axis_vfifo_tester #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHANNELS    = 2,
  parameter int BURST_LEN   = 128,
  parameter int DEPTH       = 128,
  parameter int WAIT_CYCLES = 0,
  parameter int TIMEOUT     = 512,
  parameter int RUNS        = 0
) (
  input  logic                  BUS_CLK,
  input  logic                  BUS_RST,
  input  logic                  START,

  output logic                  tx_tvalid,
  input  logic                  tx_tready,
  output logic                  tx_tlast,
  output logic [DATA_WIDTH-1:0] tx_tdata,
  output logic [1:0]            tx_tdest,

  input  logic                  rx_tvalid,
  output logic                  rx_tready,
  input  logic                  rx_tlast,
  input  logic [DATA_WIDTH-1:0] rx_tdata,
  input  logic [1:0]            rx_tdest,

  output logic                  BUSY,
  output logic                  DONE,
  output logic                  TIMEOUT_FLAG,
  output logic [7:0]            RUN_CNT,
  output logic [15:0]           ERR_CNT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_WAIT,
    S_RD,
    S_DONE
  } state_t;

  state_t state;

  // Per-channel write data counters. The array always has four entries so
  // that the 2-bit tdest indexes it directly. Only the first CHANNELS entries
  // ever advance.
  logic [DATA_WIDTH-1:0] wr_data [4];

  logic [15:0] burst_cnt;   // beats accepted so far in the current burst
  logic [31:0] phase_cnt;   // beats accepted so far in the current write phase
  logic [31:0] wait_cnt;    // idle cycles spent in WR_WAIT
  logic [31:0] rd_cnt;      // beats accepted so far in the current read phase
  logic [31:0] idle_cnt;    // consecutive read cycles without a beat

  // ---------------------------------------------------------------------------
  // Combinational helpers; all are pure functions of registered state and
  // inputs, so no defaults are needed.
  // ---------------------------------------------------------------------------
  logic                  tx_fire;
  logic                  rx_fire;
  logic [1:0]            next_ch;
  logic [DATA_WIDTH-1:0] data_after;
  logic                  phase_last;
  logic                  next_is_phase_last;
  logic                  next_is_burst_last;
  logic                  wait_last;
  logic                  rd_last;
  logic                  idle_expire;
  logic [7:0]            run_cnt_inc;
  logic                  run_stop;
  logic                  start_ok;

  assign tx_fire            = tx_tvalid && tx_tready;
  assign rx_fire            = rx_tvalid && rx_tready;
  assign next_ch            = (tx_tdest == 2'(CHANNELS - 1)) ? 2'd0 : tx_tdest + 2'd1;
  assign data_after         = wr_data[tx_tdest] + 1'b1;
  assign phase_last         = (phase_cnt + 32'd1 == 32'(DEPTH));
  // Look-ahead for the beat after the one being accepted now. This lets
  // tx_tlast be registered and valid together with tx_tvalid.
  assign next_is_phase_last = (phase_cnt + 32'd2 == 32'(DEPTH));
  assign next_is_burst_last = (burst_cnt + 16'd2 == 16'(BURST_LEN));
  assign wait_last          = (wait_cnt + 32'd1 == 32'(WAIT_CYCLES));
  assign rd_last            = (rd_cnt + 32'd1 == 32'(DEPTH));
  assign idle_expire        = (idle_cnt + 32'd1 == 32'(TIMEOUT));
  assign run_cnt_inc        = RUN_CNT + 8'd1;
  assign run_stop           = (RUNS != 0) && ({24'd0, run_cnt_inc} == 32'(RUNS));
  assign start_ok           = START && ((state == S_IDLE) || (state == S_DONE));

  // ---------------------------------------------------------------------------
  // Main FSM. All outputs are registered here.
  // ---------------------------------------------------------------------------
  // NOTE: every register in a clocked block uses <=. Then all right-hand sides
  // see the values from before the edge, whatever order the statements are in.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state        <= S_IDLE;
      tx_tvalid    <= 1'b0;
      tx_tlast     <= 1'b0;
      tx_tdata     <= '0;
      tx_tdest     <= 2'd0;
      rx_tready    <= 1'b0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      TIMEOUT_FLAG <= 1'b0;
      RUN_CNT      <= 8'd0;
      burst_cnt    <= 16'd0;
      phase_cnt    <= 32'd0;
      wait_cnt     <= 32'd0;
      rd_cnt       <= 32'd0;
      idle_cnt     <= 32'd0;
      // NOTE: this small array is cleared on purpose. These are the data
      // counters that reset and START must zero, not RAM contents.
      for (int i = 0; i < 4; i++) wr_data[i] <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            state        <= S_WR;
            tx_tvalid    <= 1'b1;
            tx_tlast     <= 1'b0;
            tx_tdata     <= '0;
            tx_tdest     <= 2'd0;
            BUSY         <= 1'b1;
            DONE         <= 1'b0;
            TIMEOUT_FLAG <= 1'b0;
            RUN_CNT      <= 8'd0;
            burst_cnt    <= 16'd0;
            phase_cnt    <= 32'd0;
            wait_cnt     <= 32'd0;
            rd_cnt       <= 32'd0;
            idle_cnt     <= 32'd0;
            for (int i = 0; i < 4; i++) wr_data[i] <= '0;
          end
        end

        S_WR: begin
          // tx_tdata/tdest/tlast change only on an accepted beat. A stalled
          // beat therefore stays on the bus unchanged.
          if (tx_fire) begin
            wr_data[tx_tdest] <= data_after;
            phase_cnt         <= phase_cnt + 32'd1;
            if (tx_tlast) begin
              burst_cnt <= 16'd0;
              tx_tdest  <= next_ch;
              // With a single channel the next burst continues this counter.
              // That includes the increment being written right now.
              tx_tdata  <= (next_ch == tx_tdest) ? data_after : wr_data[next_ch];
              tx_tlast  <= next_is_phase_last;
              if (phase_last) begin
                state     <= S_RD;
                tx_tvalid <= 1'b0;
                rx_tready <= 1'b1;
                rd_cnt    <= 32'd0;
                idle_cnt  <= 32'd0;
              end else if (WAIT_CYCLES != 0) begin
                state     <= S_WR_WAIT;
                tx_tvalid <= 1'b0;
                wait_cnt  <= 32'd0;
              end
            end else begin
              burst_cnt <= burst_cnt + 16'd1;
              tx_tdata  <= data_after;
              tx_tlast  <= next_is_burst_last || next_is_phase_last;
            end
          end
        end

        S_WR_WAIT: begin
          if (wait_last) begin
            state     <= S_WR;
            tx_tvalid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end

        S_RD: begin
          if (rx_fire) begin
            rd_cnt   <= rd_cnt + 32'd1;
            idle_cnt <= 32'd0;
          end else begin
            idle_cnt <= idle_cnt + 32'd1;
          end
          if ((rx_fire && rd_last) || (!rx_fire && idle_expire)) begin
            if (!rx_fire) TIMEOUT_FLAG <= 1'b1;
            rx_tready <= 1'b0;
            RUN_CNT   <= run_cnt_inc;
            if (run_stop) begin
              state <= S_DONE;
              DONE  <= 1'b1;
              BUSY  <= 1'b0;
            end else begin
              state     <= S_WR;
              tx_tvalid <= 1'b1;
              phase_cnt <= 32'd0;
            end
          end
        end

        default: begin
          state     <= S_IDLE;
          tx_tvalid <= 1'b0;
          rx_tready <= 1'b0;
          BUSY      <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read data checker
  // ---------------------------------------------------------------------------
`ifdef AXIS_TESTER_CHECK_EN
  logic [DATA_WIDTH-1:0] exp_data [4];
  logic [15:0]           err_cnt;
  logic                  dest_bad;
  logic                  beat_bad;
  logic                  unused_rx_tlast;

  assign dest_bad        = (32'(rx_tdest) >= 32'(CHANNELS));
  assign beat_bad        = dest_bad || (rx_tdata != exp_data[rx_tdest]);
  assign unused_rx_tlast = rx_tlast;

  // The expected counter advances on every beat, even a bad one. One
  // corrupted word then costs exactly one error, not a whole-phase slip.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST || start_ok) begin
      err_cnt <= 16'd0;
      for (int i = 0; i < 4; i++) exp_data[i] <= '0;
    end else if ((state == S_RD) && rx_fire) begin
      if (!dest_bad) exp_data[rx_tdest] <= exp_data[rx_tdest] + 1'b1;
      if (beat_bad && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end
  end

  assign ERR_CNT = err_cnt;
`else
  logic unused_rx;

  assign unused_rx = ^{rx_tdata, rx_tdest, rx_tlast};
  assign ERR_CNT   = 16'd0;
`endif

endmodule

// File: doc/axis_vfifo_tester.md
AXIS_VFIFO_TESTER -- requirements
Module: axis_vfifo_tester

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of tx_tdata/rx_tdata, 8..64.
REQ-002 Parameter CHANNELS, default 2: number of stream channels, 1..4.
REQ-003 Parameter BURST_LEN, default 128: beats per burst, 2..4096.
REQ-004 Parameter DEPTH, default 128: beats per write phase and per read phase, at least BURST_LEN.
REQ-005 Parameter WAIT_CYCLES, default 0: idle cycles inserted after each write burst; 0 means none.
REQ-006 Parameter TIMEOUT, default 512: consecutive read cycles without a beat before the read phase aborts.
REQ-007 Parameter RUNS, default 0: write/read runs before stopping; 0 means run forever.
REQ-008 BUS_CLK  in  1  sole clock; all logic on the rising edge.
REQ-009 BUS_RST  in  1  reset, synchronous, active-high.
REQ-010 START  in  1  pulse; starts a test from IDLE or DONE.
REQ-011 tx_tvalid/tx_tready/tx_tlast  out/in/out  1 each  AXI-stream master toward the FIFO.
REQ-012 tx_tdata  out  DATA_WIDTH  generated data.
REQ-013 tx_tdest  out  2  channel of the current beat.
REQ-014 rx_tvalid/rx_tready/rx_tlast  in/out/in  1 each  AXI-stream slave from the FIFO.
REQ-015 rx_tdata  in  DATA_WIDTH; rx_tdest  in  2.
REQ-016 BUSY, DONE, TIMEOUT_FLAG  out  1 each  status.
REQ-017 RUN_CNT  out  8  completed runs; ERR_CNT  out  16  data mismatches.

Function
REQ-018 FSM states: IDLE, WR, WR_WAIT, RD, DONE; BUSY is high in WR, WR_WAIT and RD.
REQ-019 IDLE or DONE, START=1 -> WR next cycle; clear RUN_CNT, ERR_CNT, TIMEOUT_FLAG and all data counters on the same edge.
REQ-020 START shall be ignored in WR, WR_WAIT and RD.
REQ-021 WR: tx_tvalid=1; a beat counts only on tx_tvalid&&tx_tready; tx_tdata/tx_tdest/tx_tlast shall stay stable while tx_tvalid&&!tx_tready.
REQ-022 Write data for channel c = a per-channel DATA_WIDTH-bit counter starting at 0, +1 per accepted beat, wrapping modulo 2^DATA_WIDTH.
REQ-023 tx_tlast=1 on the BURST_LEN-th beat of each burst and on the DEPTH-th beat of the phase.
REQ-024 After each tlast beat, tx_tdest advances (c+1) mod CHANNELS; with CHANNELS=1 it stays 0.
REQ-025 After a tlast beat with WAIT_CYCLES>0 and fewer than DEPTH beats sent -> WR_WAIT, tx_tvalid=0 for exactly WAIT_CYCLES cycles, then WR.
REQ-026 After the DEPTH-th accepted beat -> RD next cycle, tx_tvalid=0.
REQ-027 RD: rx_tready=1; a beat counts on rx_tvalid&&rx_tready; the idle counter clears on each beat and increments otherwise.
REQ-028 RD ends after DEPTH beats, or when the idle counter reaches TIMEOUT; the timeout also sets TIMEOUT_FLAG, which is sticky until START or reset.
REQ-029 At the end of RD: rx_tready=0 and RUN_CNT increments, wrapping at 8 bits; if RUNS!=0 and the new RUN_CNT==RUNS -> DONE, else -> WR.
REQ-030 DONE: DONE=1, tx_tvalid=0, rx_tready=0; the block holds until START or reset.
REQ-031 rx_tlast shall be ignored for phase termination.

Reset
REQ-032 BUS_RST=1 at any time, including mid-burst, forces IDLE on the next edge.
REQ-033 Reset clears all outputs to 0: tx_tvalid, tx_tlast, tx_tdata, tx_tdest, rx_tready, BUSY, DONE, TIMEOUT_FLAG, RUN_CNT, ERR_CNT.
REQ-034 Reset clears all counters; an in-flight beat is dropped without a handshake.

Configuration
REQ-035 Macro AXIS_TESTER_CHECK_EN, when defined, compares each accepted read beat against the expected per-channel counter for rx_tdest.
REQ-036 With the macro defined, ERR_CNT increments on a data mismatch or on rx_tdest>=CHANNELS, saturating at 16'hFFFF; the expected counter advances on every beat, matched or not.
REQ-037 Without the macro, ERR_CNT is constant 0 and no expected-data logic exists; read beats are counted only.

Verification
REQ-038 Defaults, FIFO loopback always ready, START -> 128 beats with tdata 0..127, tlast on beat 128, tdest=0; then 128 reads; RUN_CNT=1; ERR_CNT=0.
REQ-039 CHANNELS=2, BURST_LEN=4, DEPTH=8, WAIT_CYCLES=3 -> tdest 0,0,0,0,1,1,1,1; tdata 0..3 on both channels; 3 idle cycles between bursts.
REQ-040 tx_tready held low for 5 cycles mid-burst -> tx_tdata stable across the stall; beat count unchanged during the stall.
REQ-041 CHECK_EN defined, one read beat corrupted -> ERR_CNT=1; rx_tvalid never asserted -> TIMEOUT_FLAG=1 after 512 idle cycles, RUN_CNT=1.
REQ-042 RUNS=2 -> DONE=1 and BUSY=0 after the 2nd read phase; BUS_RST pulsed during WR -> next-cycle tx_tvalid=0 and state IDLE.
